vertex_transform_pipe: RTL and testbench

//  Streaming fixed-point 3D vertex transform: out = sat(R*v + t) per vertex, where R is a 3x3 coefficient

---
 rtl/gfx_pkg.sv | 41 ++++
 rtl/vt_row_mac.sv | 67 ++++++
 rtl/vertex_transform_pipe.sv | 143 ++++++++++++++
 tb/tb_vertex_transform_pipe.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gfx_pkg.sv
// Shared definitions for the vertex transform pipeline: width defaults,
// config register map, commit FSM states and the saturation helper.
package gfx_pkg;

  localparam int DEF_COORD_W   = 16;
  localparam int DEF_COEF_W    = 16;
  localparam int DEF_COEF_FRAC = 14;
  localparam int DEF_CNT_W     = 16;

  localparam logic [3:0] CFG_R00 = 4'd0;
  localparam logic [3:0] CFG_R01 = 4'd1;
  localparam logic [3:0] CFG_R02 = 4'd2;
  localparam logic [3:0] CFG_R10 = 4'd3;
  localparam logic [3:0] CFG_R11 = 4'd4;
  localparam logic [3:0] CFG_R12 = 4'd5;
  localparam logic [3:0] CFG_R20 = 4'd6;
  localparam logic [3:0] CFG_R21 = 4'd7;
  localparam logic [3:0] CFG_R22 = 4'd8;
  localparam logic [3:0] CFG_TX  = 4'd9;
  localparam logic [3:0] CFG_TY  = 4'd10;
  localparam logic [3:0] CFG_TZ  = 4'd11;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_SWAP  = 2'd2
  } vt_state_e;

  // Clamp a wide signed value into the signed range of a w-bit result.
  function automatic logic signed [63:0] sat_s(input logic signed [63:0] v,
                                               input int unsigned w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    else if (v < lo) return lo;
    else return v;
  endfunction

endpackage

// File: rtl/vt_row_mac.sv
// One output row of the transform: three products, rounded sum, shift,
// translate and saturate across three enabled pipeline stages.
module vt_row_mac
  import gfx_pkg::*;
#(
  parameter int COORD_W   = DEF_COORD_W,
  parameter int COEF_W    = DEF_COEF_W,
  parameter int COEF_FRAC = DEF_COEF_FRAC
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic [COORD_W-1:0] z,
  input  logic [COEF_W-1:0]  c0,
  input  logic [COEF_W-1:0]  c1,
  input  logic [COEF_W-1:0]  c2,
  input  logic [COORD_W-1:0] t,
  output logic [COORD_W-1:0] o
);

  localparam int PW = COORD_W + COEF_W;
  localparam int SW = PW + 2;
  localparam int VW = SW + 1;
  localparam logic signed [SW-1:0] RND = SW'(1) <<< (COEF_FRAC - 1);

  logic signed [PW-1:0] p0, p1, p2;
  logic signed [SW-1:0] acc, acc_n, shr;
  logic signed [VW-1:0] tv;
  logic [COORD_W-1:0]   o_q, o_n;

  function automatic logic signed [PW-1:0] mul(input logic [COORD_W-1:0] a,
                                               input logic [COEF_W-1:0]  b);
    logic signed [PW-1:0] aw;
    logic signed [PW-1:0] bw;
    aw = PW'($signed(a));
    bw = PW'($signed(b));
    return aw * bw;
  endfunction

  always_comb begin
    acc_n = SW'(p0) + SW'(p1) + SW'(p2) + RND;
    shr   = acc >>> COEF_FRAC;
    tv    = VW'(shr) + VW'($signed(t));
    o_n   = COORD_W'(sat_s(64'(tv), COORD_W));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p0  <= '0;
      p1  <= '0;
      p2  <= '0;
      acc <= '0;
      o_q <= '0;
    end else if (en) begin
      p0  <= mul(x, c0);
      p1  <= mul(y, c1);
      p2  <= mul(z, c2);
      acc <= acc_n;
      o_q <= o_n;
    end
  end

  assign o = o_q;

endmodule

// File: rtl/vertex_transform_pipe.sv
// Streaming vertex transform out = sat(R*v + t) with double-buffered
// configuration committed only once the pipeline has drained.
module vertex_transform_pipe
  import gfx_pkg::*;
#(
  parameter int COORD_W   = DEF_COORD_W,
  parameter int COEF_W    = DEF_COEF_W,
  parameter int COEF_FRAC = DEF_COEF_FRAC,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [3:0]         cfg_addr,
  input  logic [COEF_W-1:0]  cfg_wdata,
  input  logic               cfg_commit,
  output logic               cfg_busy,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [COORD_W-1:0] in_x,
  input  logic [COORD_W-1:0] in_y,
  input  logic [COORD_W-1:0] in_z,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [COORD_W-1:0] out_x,
  output logic [COORD_W-1:0] out_y,
  output logic [COORD_W-1:0] out_z,
  output logic               out_last,
  output logic [CNT_W-1:0]   vert_count
);

  localparam logic [COEF_W-1:0] ONE = COEF_W'(1 << COEF_FRAC);

  vt_state_e          state;
  logic [COEF_W-1:0]  sh_r [9];
  logic [COEF_W-1:0]  ac_r [9];
  logic [COORD_W-1:0] sh_t [3];
  logic [COORD_W-1:0] ac_t [3];
  logic [COORD_W-1:0] row_o [3];
  logic               v1, v2, v3, l1, l2, l3;
  logic               adv, fire, pipe_empty;
  logic [CNT_W-1:0]   cnt;

  assign adv        = !v3 || out_ready;
  assign in_ready   = adv && (state == ST_RUN);
  assign fire       = in_valid && in_ready;
  assign pipe_empty = !v1 && !v2 && !v3;
  assign cfg_busy   = (state != ST_RUN);

  // Active set only changes in SWAP, when no vertex can be in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < 9; i++) begin
        sh_r[i] <= (i % 4 == 0) ? ONE : '0;
        ac_r[i] <= (i % 4 == 0) ? ONE : '0;
      end
      for (int unsigned i = 0; i < 3; i++) begin
        sh_t[i] <= '0;
        ac_t[i] <= '0;
      end
    end else begin
      if (cfg_we) begin
        case (cfg_addr)
          CFG_R00, CFG_R01, CFG_R02,
          CFG_R10, CFG_R11, CFG_R12,
          CFG_R20, CFG_R21, CFG_R22: sh_r[cfg_addr] <= cfg_wdata;
          CFG_TX:  sh_t[0] <= cfg_wdata[COORD_W-1:0];
          CFG_TY:  sh_t[1] <= cfg_wdata[COORD_W-1:0];
          CFG_TZ:  sh_t[2] <= cfg_wdata[COORD_W-1:0];
          default: ;
        endcase
      end
      if (state == ST_SWAP) begin
        ac_r <= sh_r;
        ac_t <= sh_t;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_RUN;
    end else begin
      case (state)
        ST_RUN:   if (cfg_commit) state <= ST_DRAIN;
        ST_DRAIN: if (pipe_empty) state <= ST_SWAP;
        ST_SWAP:  state <= ST_RUN;
        default:  state <= ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1  <= 1'b0;
      v2  <= 1'b0;
      v3  <= 1'b0;
      l1  <= 1'b0;
      l2  <= 1'b0;
      l3  <= 1'b0;
      cnt <= '0;
    end else begin
      if (adv) begin
        v1 <= fire;
        l1 <= fire && in_last;
        v2 <= v1;
        l2 <= l1;
        v3 <= v2;
        l3 <= l2;
      end
      if (v3 && out_ready) cnt <= l3 ? '0 : cnt + CNT_W'(1);
    end
  end

  for (genvar r = 0; r < 3; r++) begin : g_row
    vt_row_mac #(
      .COORD_W  (COORD_W),
      .COEF_W   (COEF_W),
      .COEF_FRAC(COEF_FRAC)
    ) u_row (
      .clk (clk),
      .rst (rst),
      .en  (adv),
      .x   (in_x),
      .y   (in_y),
      .z   (in_z),
      .c0  (ac_r[r*3]),
      .c1  (ac_r[r*3+1]),
      .c2  (ac_r[r*3+2]),
      .t   (ac_t[r]),
      .o   (row_o[r])
    );
  end

  assign out_valid  = v3;
  assign out_last   = l3;
  assign out_x      = row_o[0];
  assign out_y      = row_o[1];
  assign out_z      = row_o[2];
  assign vert_count = cnt;

endmodule

// File: tb/tb_vertex_transform_pipe.sv
// Directed bench for vertex_transform_pipe: scoreboard of expected vertices
// built from a reference model of the transform and its config commit.
module tb_vertex_transform_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_we = 1'b0;
  logic [3:0]  cfg_addr = '0;
  logic [15:0] cfg_wdata = '0;
  logic        cfg_commit = 1'b0;
  logic        cfg_busy;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_x = '0, in_y = '0, in_z = '0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_x, out_y, out_z;
  logic        out_last;
  logic [15:0] vert_count;

  int          errors = 0;
  int          checks = 0;
  int          outs = 0;
  int          exp_cnt = 0;
  logic [48:0] sb[$];
  int signed   m_sh[12];
  int signed   m_ac[12];
  logic        bp_mode = 1'b0;
  logic        ready_force = 1'b1;
  logic        prev_stall = 1'b0;
  logic [48:0] prev_out = '0;

  vertex_transform_pipe #(
    .COORD_W  (16),
    .COEF_W   (16),
    .COEF_FRAC(14),
    .CNT_W    (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .cfg_commit(cfg_commit),
    .cfg_busy  (cfg_busy),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_y      (in_y),
    .in_z      (in_z),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_x     (out_x),
    .out_y     (out_y),
    .out_z     (out_z),
    .out_last  (out_last),
    .vert_count(vert_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    out_ready = bp_mode ? 1'($urandom_range(0, 1)) : ready_force;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] s16(input int v);
    return v[15:0];
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 12; i++) begin
      m_sh[i] = (i == 0 || i == 4 || i == 8) ? 16384 : 0;
      m_ac[i] = m_sh[i];
    end
  endfunction

  // out_row = sat(((sum c*v) + 0.5 lsb) floor-shifted by 14, plus t)
  function automatic logic [15:0] mrow(input int r, input int signed x, input int signed y,
                                       input int signed z);
    longint s;
    s = longint'(m_ac[r*3]) * x + longint'(m_ac[r*3+1]) * y + longint'(m_ac[r*3+2]) * z + 64'sd8192;
    s = (s >>> 14) + longint'(m_ac[9+r]);
    if (s > 32767) s = 32767;
    else if (s < -32768) s = -32768;
    return s[15:0];
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      exp_cnt = 0;
      model_reset();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", out_valid, 1'b1);
        check("stall_hold", {out_last, out_x, out_y, out_z}, prev_out);
      end
      check("vert_count", vert_count, exp_cnt);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_out", {out_last, out_x, out_y, out_z}, 49'h0);
        end else begin
          check("out_vertex", {out_last, out_x, out_y, out_z}, sb.pop_front());
        end
        exp_cnt = out_last ? 0 : (exp_cnt + 1) % 65536;
        outs++;
      end
      if (in_valid && in_ready)
        sb.push_back({in_last,
                      mrow(0, $signed(in_x), $signed(in_y), $signed(in_z)),
                      mrow(1, $signed(in_x), $signed(in_y), $signed(in_z)),
                      mrow(2, $signed(in_x), $signed(in_y), $signed(in_z))});
      if (cfg_we && cfg_addr < 4'd12) m_sh[cfg_addr] = $signed(cfg_wdata);
      if (cfg_commit) m_ac = m_sh;
      prev_stall = out_valid && !out_ready;
      prev_out   = {out_last, out_x, out_y, out_z};
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z,
                      input logic last);
    int n = 0;
    in_valid = 1'b1;
    in_x = x; in_y = y; in_z = z; in_last = last;
    while (!in_ready && n < 100) begin
      step();
      n++;
    end
    check("send_accept", in_ready, 1'b1);
    if (in_ready) step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_out();
    int n = 0;
    while (!out_valid && n < 50) begin
      step();
      n++;
    end
    check("out_valid_wait", out_valid, 1'b1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (cfg_busy && n < 50) begin
      check("drain_no_ready", in_ready, 1'b0);
      step();
      n++;
    end
    check("busy_clear", cfg_busy, 1'b0);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((sb.size() != 0 || out_valid) && n < 300) begin
      step();
      n++;
    end
    check("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  task automatic cfg_wr(input int a, input int d);
    cfg_we = 1'b1;
    cfg_addr = 4'(a);
    cfg_wdata = d[15:0];
    step();
    cfg_we = 1'b0;
  endtask

  task automatic load(input int v[12]);
    for (int i = 0; i < 12; i++) cfg_wr(i, v[i]);
  endtask

  task automatic commit();
    cfg_commit = 1'b1;
    step();
    cfg_commit = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int outs0;
    int rot[12]  = '{0, -16384, 0, 16384, 0, 0, 0, 0, 16384, 10, 0, -5};
    int satm[12] = '{32767, 0, 0, 0, 32767, 0, 0, 0, 32767, 0, 0, 0};
    int gen[12]  = '{8192, 4096, -2048, 0, 16384, 100, -16384, 300, 12000, 7, -9, 100};
    int idt[11]  = '{16384, 0, 0, 0, 16384, 0, 0, 0, 16384, 1, 2};

    model_reset();
    repeat (3) step();
    rst = 1'b0;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_xyz", {out_x, out_y, out_z}, 48'h0);
    check("rst_out_last", out_last, 1'b0);
    check("rst_vert_count", vert_count, 16'd0);
    check("rst_cfg_busy", cfg_busy, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);

    // identity after reset, latency 3
    send(16'd100, s16(-50), 16'd7, 1'b0);
    n = 1;
    while (!out_valid && n < 10) begin
      step();
      n++;
    end
    check("latency", n, 3);
    check("id_xyz", {out_x, out_y, out_z}, {16'd100, s16(-50), 16'd7});
    step();
    check("id_count", vert_count, 16'd1);

    // rotate 90 deg about Z plus translation
    load(rot);
    commit();
    check("commit_busy", cfg_busy, 1'b1);
    check("commit_ready", in_ready, 1'b0);
    wait_idle();
    send(16'd3, 16'd4, 16'd5, 1'b0);
    wait_out();
    check("rot_xyz", {out_x, out_y, out_z}, {16'd6, 16'd3, 16'd0});
    step();

    // saturation at both rails
    load(satm);
    commit();
    wait_idle();
    send(16'd30000, s16(-30000), 16'd30000, 1'b0);
    wait_out();
    check("sat_xyz", {out_x, out_y, out_z}, {16'd32767, 16'h8000, 16'd32767});
    send(s16(-30000), 16'd30000, 16'd5, 1'b0);
    wait_drain();

    // random backpressure, 8 vertices back to back
    load(gen);
    commit();
    wait_idle();
    outs0 = outs;
    bp_mode = 1'b1;
    for (int i = 0; i < 8; i++)
      send(16'($urandom), 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
    wait_drain();
    bp_mode = 1'b0;
    check("bp_out_count", outs - outs0, 8);
    step();

    // commit with four vertices in flight; fourth shares the commit cycle
    for (int i = 0; i < 11; i++) cfg_wr(i, idt[i]);
    send(16'd11, 16'd22, 16'd33, 1'b0);
    send(s16(-400), 16'd500, s16(-600), 1'b0);
    send(16'd1000, 16'd2000, 16'd3000, 1'b0);
    in_valid = 1'b1;
    in_x = 16'd1234; in_y = s16(-4321); in_z = 16'd77;
    cfg_we = 1'b1; cfg_addr = 4'd11; cfg_wdata = 16'd3;
    cfg_commit = 1'b1;
    check("commit_cycle_ready", in_ready, 1'b1);
    step();
    in_valid = 1'b0; cfg_we = 1'b0; cfg_commit = 1'b0;
    check("mid_busy", cfg_busy, 1'b1);
    check("mid_ready", in_ready, 1'b0);
    wait_idle();
    send(16'd20, 16'd30, 16'd40, 1'b0);
    wait_out();
    while (out_valid && sb.size() > 1) step();
    check("new_cfg_xyz", {out_x, out_y, out_z}, {16'd21, 16'd32, 16'd43});
    send(s16(-20), 16'd0, 16'd9, 1'b0);
    send(16'd32767, s16(-32768), 16'd0, 1'b0);
    send(16'd5, 16'd6, 16'd7, 1'b0);
    wait_drain();

    // out_last clears the counter
    for (int i = 0; i < 5; i++) send(16'(i * 3), 16'(i), 16'(i + 8), i == 4);
    wait_drain();
    step();
    check("last_count", vert_count, 16'd0);

    // reset with vertices in flight
    ready_force = 1'b0;
    send(16'd1, 16'd2, 16'd3, 1'b0);
    send(16'd4, 16'd5, 16'd6, 1'b1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    ready_force = 1'b1;
    check("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_count", vert_count, 16'd0);
    check("mid_rst_busy", cfg_busy, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step();
      check("post_rst_no_out", out_valid, 1'b0);
    end
    send(16'd100, s16(-50), 16'd7, 1'b0);
    wait_out();
    check("post_rst_identity", {out_x, out_y, out_z}, {16'd100, s16(-50), 16'd7});
    wait_drain();
    repeat (3) step();
    check("final_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
